// File: rtl/updown_btn_pkg.sv
// Shared types and helpers for the up/down button conditioner.
package updown_btn_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } press_state_e;

    // Width of a down-counter that must hold the larger of the two reload values.
    function automatic int unsigned tmr_width(input int unsigned hold_cycles,
                                              input int unsigned repeat_cycles);
        int unsigned longest;
        longest = (hold_cycles > repeat_cycles) ? hold_cycles : repeat_cycles;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/updown_btn_if.sv
// Raw button inputs and conditioned step/level outputs between buttons and counter.
interface updown_btn_if;
    logic btn_up_raw;
    logic btn_dn_raw;
    logic up_pulse;
    logic down_pulse;
    logic up_level;
    logic dn_level;
    logic conflict;

    modport master (
        output btn_up_raw, btn_dn_raw,
        input  up_pulse, down_pulse, up_level, dn_level, conflict
    );

    modport slave (
        input  btn_up_raw, btn_dn_raw,
        output up_pulse, down_pulse, up_level, dn_level, conflict
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a stable-count debounce filter for one button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // level only follows s2 after DEBOUNCE_CYCLES consecutive mismatching edges
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            level <= 1'b0;
            rise  <= 1'b0;
            cnt   <= '0;
        end else begin
            s1   <= raw;
            s2   <= s1;
            rise <= 1'b0;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                rise  <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/updown_btn_conditioner.sv
// Debounces two pushbuttons and turns presses into arbitrated step pulses with auto-repeat.
module updown_btn_conditioner
    import updown_btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned HOLD_CYCLES     = 500,
    parameter int unsigned REPEAT_CYCLES   = 100,
    parameter bit          REPEAT_EN       = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    updown_btn_if.slave  bus
);
    localparam int unsigned      TMR_W     = tmr_width(HOLD_CYCLES, REPEAT_CYCLES);
    localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] REP_LOAD  = TMR_W'(REPEAT_CYCLES - 1);

    // Channel index 0 = up, 1 = down.
    logic [1:0]   level;
    logic [1:0]   rise;
    press_state_e state_q [2];
    press_state_e state_d [2];
    logic [TMR_W-1:0] tmr_q [2];
    logic [TMR_W-1:0] tmr_d [2];
    logic [1:0]   fire_c;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_up_raw),
        .level (level[0]),
        .rise  (rise[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk   (clk),
        .rst   (rst),
        .raw   (bus.btn_dn_raw),
        .level (level[1]),
        .rise  (rise[1])
    );

    // Press FSM next-state: first pulse on rise, then HOLD delay, then periodic repeats.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            tmr_d[i]   = tmr_q[i];
            fire_c[i]  = 1'b0;
            case (state_q[i])
                IDLE: begin
                    if (rise[i]) begin
                        fire_c[i]  = 1'b1;
                        tmr_d[i]   = HOLD_LOAD;
                        state_d[i] = HOLD;
                    end
                end
                HOLD: begin
                    if (!level[i]) begin
                        state_d[i] = IDLE;
                    end else if (tmr_q[i] == '0) begin
                        if (REPEAT_EN) begin
                            fire_c[i]  = 1'b1;
                            tmr_d[i]   = REP_LOAD;
                            state_d[i] = REPEAT;
                        end
                    end else begin
                        tmr_d[i] = tmr_q[i] - TMR_W'(1);
                    end
                end
                REPEAT: begin
                    if (!level[i]) begin
                        state_d[i] = IDLE;
                    end else if (tmr_q[i] == '0) begin
                        fire_c[i] = 1'b1;
                        tmr_d[i]  = REP_LOAD;
                    end else begin
                        tmr_d[i] = tmr_q[i] - TMR_W'(1);
                    end
                end
                default: state_d[i] = IDLE;
            endcase
        end
    end

    // State, timers and arbitrated outputs; simultaneous pulses cancel and flag a conflict.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= IDLE;
                tmr_q[i]   <= '0;
            end
            bus.up_pulse   <= 1'b0;
            bus.down_pulse <= 1'b0;
            bus.up_level   <= 1'b0;
            bus.dn_level   <= 1'b0;
            bus.conflict   <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                tmr_q[i]   <= tmr_d[i];
            end
            bus.up_pulse   <= fire_c[0] & ~fire_c[1];
            bus.down_pulse <= fire_c[1] & ~fire_c[0];
            bus.conflict   <= fire_c[0] & fire_c[1];
            bus.up_level   <= level[0];
            bus.dn_level   <= level[1];
        end
    end
endmodule

// File: tb/tb_updown_btn_conditioner.sv
// Directed bench for updown_btn_conditioner (DB=4, HOLD=20, REPEAT=5), with and without auto-repeat.
module tb_updown_btn_conditioner;

    logic clk;
    logic rst;
    logic up_raw;
    logic dn_raw;
    int   n_tests;
    int   n_fail;

    updown_btn_if bus_r ();
    updown_btn_if bus_n ();

    assign bus_r.btn_up_raw = up_raw;
    assign bus_r.btn_dn_raw = dn_raw;
    assign bus_n.btn_up_raw = up_raw;
    assign bus_n.btn_dn_raw = dn_raw;

    updown_btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (5),
        .REPEAT_EN       (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_r)
    );

    updown_btn_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (5),
        .REPEAT_EN       (1'b0)
    ) dut_nr (
        .clk (clk),
        .rst (rst),
        .bus (bus_n)
    );

    logic [4:0] outs_r;
    logic [4:0] outs_n;
    assign outs_r = {bus_r.up_pulse, bus_r.down_pulse, bus_r.up_level, bus_r.dn_level, bus_r.conflict};
    assign outs_n = {bus_n.up_pulse, bus_n.down_pulse, bus_n.up_level, bus_n.dn_level, bus_n.conflict};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        check(tag, 8'(obs), 8'(exp));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        up_raw  = 1'b0;
        dn_raw  = 1'b0;

        // 1: reset held with toggling inputs
        #1;
        check("t1_rst_init", 8'(outs_r), 8'h00);
        for (int k = 0; k < 3; k++) begin
            up_raw = k[0];
            dn_raw = ~k[0];
            tick();
            check("t1_rst_r", 8'(outs_r), 8'h00);
            check("t1_rst_n", 8'(outs_n), 8'h00);
        end
        up_raw = 1'b0;
        dn_raw = 1'b0;
        rst    = 1'b1;

        // 2: clean up press, first pulse after edge 7
        up_raw = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk1("t2_up_pulse", bus_r.up_pulse, k == 7);
            chk1("t2_up_level", bus_r.up_level, k >= 7);
            chk1("t2_dn_pulse", bus_r.down_pulse, 1'b0);
        end
        up_raw = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            chk1("t2_rel_pulse", bus_r.up_pulse, 1'b0);
        end
        chk1("t2_rel_level", bus_r.up_level, 1'b0);

        // 3: bounce shorter than the filter
        up_raw = 1'b1; tick();
        up_raw = 1'b0; tick();
        up_raw = 1'b1; tick();
        up_raw = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            chk1("t3_pulse", bus_r.up_pulse, 1'b0);
            chk1("t3_level", bus_r.up_level, 1'b0);
        end

        // 4: held down button, auto-repeat vs single pulse
        dn_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk1("t4_first_r", bus_r.down_pulse, k == 7);
            chk1("t4_first_n", bus_n.down_pulse, k == 7);
        end
        for (int off = 1; off <= 60; off++) begin
            // raw drops early enough that the debounced level falls right after the +40 pulse
            if (off == 39) dn_raw = 1'b0;
            tick();
            chk1("t4_rep_r", bus_r.down_pulse, off inside {20, 25, 30, 35, 40});
            chk1("t4_rep_n", bus_n.down_pulse, 1'b0);
            chk1("t4_up", bus_r.up_pulse, 1'b0);
            chk1("t4_level", bus_r.dn_level, off < 45);
        end

        // 5: simultaneous press, then a collision between repeat and a new press
        up_raw = 1'b1;
        dn_raw = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk1("t5_conflict", bus_r.conflict, k == 7);
            chk1("t5_up", bus_r.up_pulse, 1'b0);
            chk1("t5_dn", bus_r.down_pulse, 1'b0);
        end
        up_raw = 1'b0;
        for (int off = 1; off <= 41; off++) begin
            if (off == 24) up_raw = 1'b1;
            tick();
            chk1("t5_dn_rep", bus_r.down_pulse, off inside {20, 25, 35, 40});
            chk1("t5_up_rep", bus_r.up_pulse, 1'b0);
            chk1("t5_conf_rep", bus_r.conflict, off == 30);
            chk1("t5_excl", !(bus_r.up_pulse && bus_r.down_pulse), 1'b1);
        end
        chk1("t5_up_level", bus_r.up_level, 1'b1);
        chk1("t5_dn_level", bus_r.dn_level, 1'b1);

        // 6: asynchronous reset mid-repeat with down still held
        rst    = 1'b0;
        up_raw = 1'b0;
        #1;
        check("t6_rst_now", 8'(outs_r), 8'h00);
        tick();
        check("t6_rst_hold", 8'(outs_r), 8'h00);
        tick();
        check("t6_rst_hold", 8'(outs_r), 8'h00);
        rst = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk1("t6_first", bus_r.down_pulse, k == 7);
            chk1("t6_up", bus_r.up_pulse, 1'b0);
        end
        for (int off = 1; off <= 20; off++) begin
            tick();
            chk1("t6_hold", bus_r.down_pulse, off == 20);
            chk1("t6_conf", bus_r.conflict, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
